// File: rtl/expr_eval_pkg.sv
// Shared constants, FSM encoding and character-class record for the expression evaluator.
package expr_pkg;

   localparam logic [7:0] CH_MUL  = 8'd42;
   localparam logic [7:0] CH_ADD  = 8'd43;
   localparam logic [7:0] CH_ZERO = 8'd48;
   localparam logic [7:0] CH_NINE = 8'd57;

   typedef enum logic [1:0] {
      EXP_NUM = 2'd0,
      EXP_OP  = 2'd1,
      ERR     = 2'd2
   } state_t;

   typedef struct packed {
      logic       is_digit;
      logic       is_add;
      logic       is_mul;
      logic [3:0] digit;
   } char_t;

endpackage

// File: rtl/expr_eval_char_class.sv
// Combinational ASCII classifier: digit / '+' / '*' flags plus the digit value.
module char_class
   import expr_pkg::*;
(
   input  logic [7:0] in,
   output char_t      cls
);

   logic [7:0] offset;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cls          = '0;
      offset       = in - CH_ZERO;
      cls.is_digit = (in >= CH_ZERO) && (in <= CH_NINE);
      cls.is_add   = (in == CH_ADD);
      cls.is_mul   = (in == CH_MUL);
      cls.digit    = offset[3:0];
   end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions with precedence, 32-bit wrap.
module expr_eval
   import expr_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in,
   output logic [31:0] result,
   output logic        ok,
   output logic        err,
   output logic        ovf,
   output logic [7:0]  count
);

   state_t      state;
   char_t       cls;
   logic [31:0] sum;
   logic [31:0] prod;
   logic        mul_pend;

   logic [35:0] prod_full;
   logic [31:0] new_prod;
   logic        prod_ovf;
   logic [32:0] term_sum;
   logic [32:0] add_sum;

   char_class u_char_class (
      .in  (in),
      .cls (cls)
   );

   // Term arithmetic is widened so the carry-out doubles as the wrap detector.
   always_comb begin
      prod_full = {4'd0, prod} * {32'd0, cls.digit};
      prod_ovf  = mul_pend && (prod_full[35:32] != 4'd0);
      new_prod  = mul_pend ? prod_full[31:0] : {28'd0, cls.digit};
      term_sum  = {1'b0, sum} + {1'b0, new_prod};
      add_sum   = {1'b0, sum} + {1'b0, prod};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= EXP_NUM;
         sum      <= '0;
         prod     <= '0;
         mul_pend <= 1'b0;
         result   <= '0;
         ok       <= 1'b0;
         err      <= 1'b0;
         ovf      <= 1'b0;
         count    <= '0;
      end else if (in_valid && (state != ERR)) begin
         if (count != 8'hFF) count <= count + 8'd1;
         case (state)
            EXP_NUM: begin
               if (cls.is_digit) begin
                  state  <= EXP_OP;
                  ok     <= 1'b1;
                  prod   <= new_prod;
                  result <= term_sum[31:0];
                  if (prod_ovf || term_sum[32]) ovf <= 1'b1;
               end else begin
                  state <= ERR;
                  err   <= 1'b1;
               end
            end
            EXP_OP: begin
               ok <= 1'b0;
               if (cls.is_add) begin
                  state    <= EXP_NUM;
                  sum      <= add_sum[31:0];
                  mul_pend <= 1'b0;
                  if (add_sum[32]) ovf <= 1'b1;
               end else if (cls.is_mul) begin
                  state    <= EXP_NUM;
                  mul_pend <= 1'b1;
               end else begin
                  state <= ERR;
                  err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: hand-computed expectations checked with immediate assertions.
module tb_expr_eval;
   import expr_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_ch = 8'd0;
   logic [31:0] result;
   logic        ok;
   logic        err;
   logic        ovf;
   logic [7:0]  count;

   int checks   = 0;
   int failures = 0;

   expr_eval dut (
      .clk      (clk),
      .clr      (clr),
      .in_valid (in_valid),
      .in       (in_ch),
      .result   (result),
      .ok       (ok),
      .err      (err),
      .ovf      (ovf),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      in_valid = 1'b1;
      in_ch    = c;
      @(negedge clk);
      in_valid = 1'b0;
      in_ch    = 8'd0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      clr = 1'b0;
      check("rst_result", result, 0);
      check("rst_ok", ok, 0);
      check("rst_err", err, 0);
      check("rst_ovf", ovf, 0);
      check("rst_count", count, 0);

      // precedence: 1+2*3
      send_str("1+2*");
      check("p_mid_result", result, 3);
      check("p_mid_ok", ok, 0);
      send_str("3");
      check("p_result", result, 7);
      check("p_ok", ok, 1);
      check("p_err", err, 0);
      check("p_count", count, 5);

      do_clr();
      send_str("2*3*4+5");
      check("chain_result", result, 29);
      check("chain_ok", ok, 1);

      do_clr();
      send_str("2*3*4+");
      check("trail_result", result, 24);
      check("trail_ok", ok, 0);
      check("trail_count", count, 6);

      // leading operator, then ERR absorbs further input
      do_clr();
      send_str("+");
      check("lead_err", err, 1);
      check("lead_result", result, 0);
      check("lead_ok", ok, 0);
      send_str("1");
      check("lead_absorb_count", count, 1);
      check("lead_absorb_result", result, 0);

      // two digits in a row
      do_clr();
      send_str("1");
      check("dd_first_err", err, 0);
      send_str("2");
      check("dd_err", err, 1);
      check("dd_result", result, 1);
      check("dd_count", count, 2);

      // illegal code
      do_clr();
      send_str("a");
      check("ill_err", err, 1);
      check("ill_count", count, 1);

      // 9^10 fits, 9^11 wraps
      do_clr();
      send_str("9");
      for (int i = 0; i < 9; i++) send_str("*9");
      check("pow10_result", result, 32'd3486784401);
      check("pow10_ovf", ovf, 0);
      send_str("*9");
      check("pow11_ovf", ovf, 1);
      check("pow11_result", result, 32'd1316288537);
      check("pow11_ok", ok, 1);
      check("pow11_count", count, 21);

      // clr beats a simultaneous character
      do_clr();
      send_str("3*");
      @(negedge clk);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_ch    = "5";
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      check("clrpri_count", count, 0);
      check("clrpri_result", result, 0);
      send_str("4");
      check("clrpri_result4", result, 4);
      check("clrpri_ok", ok, 1);
      check("clrpri_count1", count, 1);

      // gaps between characters
      do_clr();
      send_str("1");
      repeat (3) @(negedge clk);
      check("gap1_result", result, 1);
      check("gap1_ok", ok, 1);
      check("gap1_count", count, 1);
      send_str("+");
      repeat (3) @(negedge clk);
      check("gap2_result", result, 1);
      check("gap2_ok", ok, 0);
      check("gap2_count", count, 2);
      send_str("2");
      check("gap_result", result, 3);
      check("gap_ok", ok, 1);

      // count saturation: 128 ones and 127 '+' = 255 chars, then two more
      do_clr();
      send_str("1");
      for (int i = 0; i < 127; i++) send_str("+1");
      check("sat_count", count, 255);
      check("sat_result", result, 128);
      send_str("+1");
      check("sat_hold_count", count, 255);
      check("sat_result2", result, 129);
      check("sat_ovf", ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
